soc_run_monitor: RTL

//   Run-completion monitor that sits downstream of zeroriscy_soc and consumes its
//   mem_flag / mem_result / instr_addr outputs. Detects program completion, checks
//   the result and flags timeouts and PC hangs. Replaces ad-hoc bench-side
//   $finish logic with a synthesizable, reusable block.

---
 rtl/soc_run_monitor_if.sv | 28 ++
 rtl/soc_run_monitor.sv | 105 ++++++++++
 2 files changed

// File: rtl/soc_run_monitor_if.sv
// Bundle between zeroriscy_soc-side signals and the run-completion monitor.
interface soc_run_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             fetch_enable_i;
  logic [31:0]      mem_flag_i;
  logic [31:0]      mem_result_i;
  logic [31:0]      instr_addr_i;
  logic             done_o;
  logic             pass_o;
  logic             fail_o;
  logic             timeout_o;
  logic             hang_o;
  logic [31:0]      result_o;
  logic [CNT_W-1:0] cycles_o;

  // SoC / bench side: drives the observed signals, reads the verdict.
  modport master (
    output fetch_enable_i, mem_flag_i, mem_result_i, instr_addr_i,
    input  done_o, pass_o, fail_o, timeout_o, hang_o, result_o, cycles_o
  );

  // Monitor side.
  modport slave (
    input  fetch_enable_i, mem_flag_i, mem_result_i, instr_addr_i,
    output done_o, pass_o, fail_o, timeout_o, hang_o, result_o, cycles_o
  );
endinterface

// File: rtl/soc_run_monitor.sv
// Run-completion monitor: watches SoC flag/result/PC and latches a sticky
// pass / fail / timeout / hang verdict.
module soc_run_monitor #(
  parameter int unsigned TIMEOUT_CYCLES  = 100,
  parameter int unsigned STALL_CYCLES    = 32,
  parameter logic [31:0] EXPECTED_RESULT = 32'd0,
  parameter int unsigned CHECK_RESULT    = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  soc_run_monitor_if.slave  bus
);

  localparam int unsigned STALL_W    = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam int unsigned STALL_LAST = (STALL_CYCLES == 0) ? 0 : STALL_CYCLES - 1;
  localparam int unsigned TMO_LAST   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT, S_HANG
  } state_e;

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cycles, w_cycles_nxt;
  logic [STALL_W-1:0] r_stall, w_stall_nxt;
  logic [31:0]        r_last_addr, w_last_addr_nxt;
  logic [31:0]        r_result, w_result_nxt;
  logic               r_done, r_pass, r_fail, r_timeout, r_hang;
  logic               w_addr_same;
  logic               w_result_ok;

  assign w_addr_same = (bus.instr_addr_i == r_last_addr);
  assign w_result_ok = (CHECK_RESULT == 0) || (bus.mem_result_i == EXPECTED_RESULT);

  // Next-state and next counter values; priority flag > timeout > hang.
  always_comb begin
    w_state_nxt     = r_state;
    w_cycles_nxt    = r_cycles;
    w_stall_nxt     = r_stall;
    w_last_addr_nxt = r_last_addr;
    w_result_nxt    = r_result;
    case (r_state)
      S_IDLE: begin
        w_cycles_nxt    = '0;
        w_stall_nxt     = '0;
        w_last_addr_nxt = bus.instr_addr_i;
        if (bus.fetch_enable_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.fetch_enable_i) begin
          w_cycles_nxt    = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);
          w_stall_nxt     = w_addr_same ? r_stall + STALL_W'(1) : '0;
          w_last_addr_nxt = bus.instr_addr_i;
          if (bus.mem_flag_i != 32'd0) begin
            w_result_nxt = bus.mem_result_i;
            w_state_nxt  = w_result_ok ? S_PASS : S_FAIL;
          end else if (r_cycles == CNT_W'(TMO_LAST)) begin
            w_state_nxt = S_TIMEOUT;
          end else if ((STALL_CYCLES != 0) && (r_stall == STALL_W'(STALL_LAST)) && w_addr_same) begin
            w_state_nxt = S_HANG;
          end
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  // State, counters and registered verdict outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cycles    <= '0;
      r_stall     <= '0;
      r_last_addr <= '0;
      r_result    <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_hang      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cycles    <= w_cycles_nxt;
      r_stall     <= w_stall_nxt;
      r_last_addr <= w_last_addr_nxt;
      r_result    <= w_result_nxt;
      r_pass      <= (w_state_nxt == S_PASS);
      r_fail      <= (w_state_nxt == S_FAIL);
      r_timeout   <= (w_state_nxt == S_TIMEOUT);
      r_hang      <= (w_state_nxt == S_HANG);
      r_done      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_RUN);
    end
  end

  assign bus.done_o    = r_done;
  assign bus.pass_o    = r_pass;
  assign bus.fail_o    = r_fail;
  assign bus.timeout_o = r_timeout;
  assign bus.hang_o    = r_hang;
  assign bus.result_o  = r_result;
  assign bus.cycles_o  = r_cycles;

endmodule
